// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative LSL/LSR/ASR/ROL shifter, one bit position per clock,
// with a start/busy/done handshake and registered result.
module shift_unit_seq #(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, dout_q, dout_d, step_w;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             cbit_q, cbit_d, cout_q, cout_d, step_c;
  assign step_w = mode_q == 2'b00 ? {work_q[WIDTH-2:0], 1'b0} :
                  mode_q == 2'b01 ? {1'b0, work_q[WIDTH-1:1]} :
                  mode_q == 2'b10 ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} :
                                    {work_q[WIDTH-2:0], work_q[WIDTH-1]};
  // right shifts lose the LSB, left shift and rotate lose the MSB
  assign step_c = (mode_q[1] ^ mode_q[0]) ? work_q[0] : work_q[WIDTH-1];
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cbit_d  = cbit_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    if (state_q == IDLE && start) begin
      work_d  = din;
      cnt_d   = amt;
      mode_d  = mode;
      cbit_d  = 1'b0;
      state_d = amt != '0 ? SHIFT : DONE;
    end else if (state_q == SHIFT) begin
      work_d  = step_w;
      cbit_d  = step_c;
      cnt_d   = cnt_q != '0 ? cnt_q - AW'(1) : cnt_q;
      state_d = cnt_q <= AW'(1) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      dout_d  = work_q;
      cout_d  = cbit_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      cbit_q  <= 1'b0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cbit_q  <= cbit_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign dout = dout_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: table vectors, handshake corner sequences and random
// operations checked against an arithmetic shift/rotate model.
module tb_shift_unit_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] din = '0;
  logic [2:0] amt = '0;
  logic [1:0] mode = '0;
  logic busy, done, cout;
  logic [W-1:0] dout;
  int checks = 0, errors = 0;
  logic [W-1:0] last_d = '0;
  logic last_c = 1'b0;

  typedef struct {
    logic [W-1:0] din;
    logic [2:0]   amt;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         c;
  } vec_t;
  vec_t tbl[7];

  shift_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .amt(amt), .mode(mode),
    .busy(busy), .done(done), .dout(dout), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [2:0] a, input logic [1:0] m);
    logic [W-1:0] r;
    logic c;
    int ai;
    ai = int'(a);
    case (m)
      2'b00:   r = d << ai;
      2'b01:   r = d >> ai;
      2'b10:   r = W'($signed(d) >>> ai);
      default: r = (d << ai) | (d >> (W - ai));
    endcase
    if (ai == 0) c = 1'b0;
    else if (m == 2'b00 || m == 2'b11) c = d[W - ai];
    else c = d[ai - 1];
    return {c, r};
  endfunction

  task automatic run_op(input logic [W-1:0] d_in, input logic [2:0] a, input logic [1:0] m,
                        input logic [W-1:0] ed, input logic ec, input bit noise);
    int n;
    @(negedge clk);
    start = 1'b1; din = d_in; amt = a; mode = m;
    @(negedge clk);
    start = 1'b0;
    if (noise) begin din = W'($urandom); amt = 3'($urandom); mode = 2'($urandom); end
    n = 0;
    while (!done && n < 20) begin
      check("busy_shift", busy, 1);
      check("dout_hold", dout, last_d);
      check("cout_hold", cout, last_c);
      if (noise) begin
        start = 1'($urandom_range(0, 1)); din = W'($urandom); amt = 3'($urandom); mode = 2'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_latency", n, a);
    check("busy_done", busy, 1);
    check("dout_hold_done", dout, last_d);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("dout", dout, ed);
    check("cout", cout, ec);
    last_d = ed;
    last_c = ec;
  endtask

  initial begin
    int dones;
    logic [W:0] e;
    logic [W-1:0] rd;
    logic [2:0] ra;
    logic [1:0] rm;
    tbl[0] = '{8'h96, 3'd3, 2'b00, 8'hB0, 1'b0};
    tbl[1] = '{8'h96, 3'd2, 2'b10, 8'hE5, 1'b1};
    tbl[2] = '{8'h96, 3'd2, 2'b01, 8'h25, 1'b1};
    tbl[3] = '{8'h96, 3'd1, 2'b11, 8'h2D, 1'b1};
    tbl[4] = '{8'h96, 3'd7, 2'b11, 8'h4B, 1'b1};
    tbl[5] = '{8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0};
    tbl[6] = '{8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].din, tbl[i].amt, tbl[i].mode, tbl[i].d, tbl[i].c, 1'b0);

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    start = 1'b1; din = 8'h01; amt = 3'd5; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin start = 1'b1; din = 8'hFF; amt = 3'd1; mode = 2'b11; end
      if (i == 3) start = 1'b0;
      if (done) dones++;
      @(negedge clk);
    end
    check("ignore_dones", dones, 1);
    check("ignore_dout", dout, 8'h20);
    check("ignore_cout", cout, 0);
    check("ignore_busy", busy, 0);
    last_d = 8'h20;
    last_c = 1'b0;

    // reset during the third SHIFT cycle discards the operation
    @(negedge clk);
    start = 1'b1; din = 8'h96; amt = 3'd6; mode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dout", dout, 0);
    check("midrst_cout", cout, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", dones, 0);
    last_d = '0;
    last_c = 1'b0;
    e = model(8'h96, 3'd6, 2'b01);
    run_op(8'h96, 3'd6, 2'b01, e[W-1:0], e[W], 1'b0);

    for (int i = 0; i < 150; i++) begin
      rd = W'($urandom);
      ra = 3'($urandom);
      rm = 2'($urandom);
      e = model(rd, ra, rm);
      run_op(rd, ra, rm, e[W-1:0], e[W], 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
